// File: rtl/audio_pkg.sv
// Shared audio-path types: the PCM sample type, playback FSM states and the
// fixed upsample ratio between the 6 kHz file rate and the 48 kHz AC97 frame rate.
package audio_pkg;

  typedef logic signed [7:0] sample_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    LOAD  = 2'd2,
    RUN   = 2'd3
  } state_t;

  localparam int UPSAMPLE_LOG2 = 3;

endpackage

// File: rtl/playback_interp_if.sv
// Sample stream from the flash read sequencer into the playback interpolator.
//
// Handshake: in_req is a level permit from the slave. The master may strobe
// in_valid for one cycle with in_sample while in_req is high (or up to 2 cycles
// after it falls); a strobe is taken if the FIFO has room or is popped in that
// same cycle, otherwise the sample is dropped and the slave flags overflow.
interface playback_interp_if;
  import audio_pkg::*;

  sample_t in_sample;
  logic    in_valid;
  logic    in_req;

  modport master (output in_sample, output in_valid, input in_req);
  modport slave  (input in_sample, input in_valid, output in_req);

endinterface

// File: rtl/sample_fifo.sv
// Small first-word-fall-through FIFO; DEPTH must be a power of two so the
// pointers wrap by plain overflow. A pop of a full FIFO makes room for a push.
module sample_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (reset || flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (do_push && !do_pop) begin
        count <= count + 1'b1;
      end else if (do_pop && !do_push) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: rtl/playback_interp.sv
// Playback stage: buffers 6 kHz PCM samples and emits one linearly interpolated,
// volume-attenuated sample per AC97 ready pulse through a 2-stage pipeline.
module playback_interp
  import audio_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int PHASE_BITS = UPSAMPLE_LOG2
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         ready,
  input  logic [2:0]                   volume,
  playback_interp_if.slave             src,
  output sample_t                      to_ac97_data,
  output logic                         underrun,
  output logic                         overflow,
  output state_t                       fsm_state,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int PW = 9 + PHASE_BITS;

  state_t                state;
  state_t                state_d;
  sample_t               prev_q;
  sample_t               next_q;
  logic [PHASE_BITS-1:0] phase_q;

  logic    fifo_pop;
  logic    fifo_push;
  logic    fifo_flush;
  logic    fifo_full;
  logic    fifo_empty;
  sample_t fifo_dout;
  logic    clear_flags;
  logic    phase_wrap;
  logic    starve;
  logic    drop;

  logic signed [8:0]    diff;
  logic signed [PW-1:0] prod;

  logic                 s1_valid;
  logic signed [PW-1:0] s1_prod;
  sample_t              s1_base;
  logic [2:0]           s1_vol;
  logic signed [PW-1:0] sum;
  sample_t              interp;

  sample_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clock (clock),
    .reset (reset),
    .flush (fifo_flush),
    .push  (fifo_push),
    .pop   (fifo_pop),
    .din   (src.in_sample),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // The FIFO is held empty in IDLE and emptied on the edge enable drops.
  assign fifo_flush = (state == IDLE) || !enable;
  assign fifo_push  = src.in_valid && (state != IDLE);
  assign src.in_req = enable && (state != IDLE) && !fifo_full;
  assign fsm_state  = state;

  assign phase_wrap = (state == RUN) && ready && (&phase_q);
  assign starve     = enable && phase_wrap && fifo_empty;
  assign drop       = enable && fifo_push && fifo_full && !fifo_pop;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d     = state;
    fifo_pop    = 1'b0;
    clear_flags = 1'b0;
    case (state)
      IDLE: begin
        if (enable) begin
          state_d     = PRIME;
          clear_flags = 1'b1;
        end
      end
      PRIME: begin
        if (fifo_count >= CW'(2)) begin
          fifo_pop = 1'b1;
          state_d  = LOAD;
        end
      end
      LOAD: begin
        fifo_pop = 1'b1;
        state_d  = RUN;
      end
      RUN: begin
        fifo_pop = phase_wrap && !fifo_empty;
      end
      default: state_d = IDLE;
    endcase
    if (!enable) begin
      state_d  = IDLE;
      fifo_pop = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || fifo_flush) begin
      prev_q  <= '0;
      next_q  <= '0;
      phase_q <= '0;
    end else begin
      case (state)
        PRIME: if (fifo_pop) prev_q <= fifo_dout;
        LOAD: begin
          next_q  <= fifo_dout;
          phase_q <= '0;
        end
        RUN: begin
          if (ready) begin
            phase_q <= phase_q + 1'b1;
            if (&phase_q) begin
              prev_q <= next_q;
              // With nothing buffered the segment extends flat at next_q.
              if (!fifo_empty) next_q <= fifo_dout;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign diff = $signed({next_q[7], next_q}) - $signed({prev_q[7], prev_q});
  assign prod = PW'(diff) * PW'($signed({1'b0, phase_q}));

  // Stage 1: product and base sample; pulses outside RUN feed zeros.
  always_ff @(posedge clock) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_prod  <= '0;
      s1_base  <= '0;
      s1_vol   <= '0;
    end else begin
      s1_valid <= ready;
      if (ready) begin
        s1_vol <= volume;
        if (state == RUN) begin
          s1_prod <= prod;
          s1_base <= prev_q;
        end else begin
          s1_prod <= '0;
          s1_base <= '0;
        end
      end
    end
  end

  // The interpolant always lies between prev and next, so the low 8 bits suffice.
  assign sum    = PW'(s1_base) + (s1_prod >>> PHASE_BITS);
  assign interp = sum[7:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      to_ac97_data <= '0;
    end else if (s1_valid) begin
      to_ac97_data <= interp >>> s1_vol;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || clear_flags) begin
      underrun <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (starve) underrun <= 1'b1;
      if (drop)   overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_playback_interp.sv
// Bench for playback_interp: tabled two-sample segments, hand-built corner
// sequences and random sessions scored against an arithmetic interpolation model.
module tb_playback_interp;
  import audio_pkg::*;

  logic       clock;
  logic       reset;
  logic       enable;
  logic       ready;
  logic [2:0] volume;
  sample_t    to_ac97_data;
  logic       underrun;
  logic       overflow;
  state_t     fsm_state;
  logic [2:0] fifo_count;

  playback_interp_if sif();

  playback_interp #(.FIFO_DEPTH(4), .PHASE_BITS(3)) dut (
    .clock        (clock),
    .reset        (reset),
    .enable       (enable),
    .ready        (ready),
    .volume       (volume),
    .src          (sif),
    .to_ac97_data (to_ac97_data),
    .underrun     (underrun),
    .overflow     (overflow),
    .fsm_state    (fsm_state),
    .fifo_count   (fifo_count)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic signed [7:0] s0;
    logic signed [7:0] s1;
    logic [2:0]        vol;
    logic [7:0][7:0]   exp;
  } vec_t;

  int         total;
  int         bad;
  logic [7:0] exp_q[$];
  int         model_s[$];
  int         feed_q[$];
  bit         feed_on;
  int         pulse_k;
  vec_t       vecs[5];

  function automatic vec_t mk(int s0, int s1, int vol, int e0, int e1, int e2, int e3,
                              int e4, int e5, int e6, int e7);
    vec_t r;
    r.s0 = 8'(s0);
    r.s1 = 8'(s1);
    r.vol = 3'(vol);
    r.exp[0] = 8'(e0); r.exp[1] = 8'(e1); r.exp[2] = 8'(e2); r.exp[3] = 8'(e3);
    r.exp[4] = 8'(e4); r.exp[5] = 8'(e5); r.exp[6] = 8'(e6); r.exp[7] = 8'(e7);
    return r;
  endfunction

  // reference model: segment j spans samples j and j+1, held flat past the last one
  function automatic int floor_div(int a, int d);
    int q;
    q = a / d;
    if ((a % d != 0) && ((a < 0) != (d < 0))) q = q - 1;
    return q;
  endfunction

  function automatic int model_out(int k, int vol);
    int last, j, p, a, b, v;
    last = model_s.size() - 1;
    j = k / 8;
    p = k % 8;
    a = model_s[(j < last) ? j : last];
    b = model_s[(j + 1 < last) ? j + 1 : last];
    v = a + floor_div((b - a) * p, 8);
    return floor_div(v, 1 << vol);
  endfunction

  task automatic check(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // driver tasks
  task automatic tick();
    @(negedge clock);
    sif.in_valid = 1'b0;
    if (feed_on && feed_q.size() > 0 && sif.in_req && ($urandom_range(0, 1) == 1)) begin
      sif.in_sample = 8'(feed_q.pop_front());
      sif.in_valid  = 1'b1;
    end
  endtask

  task automatic push_raw(input int s);
    sif.in_sample = 8'(s);
    sif.in_valid  = 1'b1;
    tick();
  endtask

  task automatic start(input int vol);
    enable = 1'b0;
    tick();
    volume = 3'(vol);
    enable = 1'b1;
    tick();
    pulse_k = 0;
  endtask

  task automatic wait_run(input string name);
    for (int n = 0; n < 60 && fsm_state != RUN; n++) tick();
    check(name, int'(fsm_state), int'(RUN));
  endtask

  task automatic pulse(input string name, input int exp);
    logic [7:0] e8;
    exp_q.push_back(8'(exp));
    ready = 1'b1;
    tick();
    ready = 1'b0;
    tick();
    e8 = exp_q.pop_front();
    check(name, int'(to_ac97_data), int'($signed(e8)));
    repeat (6 + $urandom_range(0, 3)) tick();
  endtask

  task automatic model_pulses(input string name, input int n, input int vol);
    for (int i = 0; i < n; i++) begin
      pulse($sformatf("%s_p%0d", name, pulse_k), model_out(pulse_k, vol));
      pulse_k++;
    end
  endtask

  initial begin
    total = 0;
    bad = 0;
    feed_on = 1'b0;
    reset = 1'b1;
    enable = 1'b0;
    ready = 1'b0;
    volume = 3'd0;
    sif.in_sample = '0;
    sif.in_valid = 1'b0;
    repeat (3) tick();
    check("rst_data", int'(to_ac97_data), 0);
    check("rst_in_req", int'(sif.in_req), 0);
    check("rst_underrun", int'(underrun), 0);
    check("rst_overflow", int'(overflow), 0);
    check("rst_state", int'(fsm_state), int'(IDLE));
    check("rst_count", int'(fifo_count), 0);
    reset = 1'b0;
    tick();

    // tabled segments: ramp, negative rounding, volume, full-scale both ways
    vecs[0] = mk(0, 80, 0, 0, 10, 20, 30, 40, 50, 60, 70);
    vecs[1] = mk(0, -8, 0, 0, -1, -2, -3, -4, -5, -6, -7);
    vecs[2] = mk(0, 80, 2, 0, 2, 5, 7, 10, 12, 15, 17);
    vecs[3] = mk(-128, 127, 0, -128, -97, -65, -33, -1, 31, 63, 95);
    vecs[4] = mk(127, -128, 3, 15, 11, 7, 3, -1, -5, -9, -13);
    for (int v = 0; v < 5; v++) begin
      start(int'(vecs[v].vol));
      check($sformatf("vec%0d_in_req", v), int'(sif.in_req), 1);
      push_raw(int'(vecs[v].s0));
      push_raw(int'(vecs[v].s1));
      wait_run($sformatf("vec%0d_run", v));
      for (int p = 0; p < 8; p++)
        pulse($sformatf("vec%0d_p%0d", v, p), int'($signed(vecs[v].exp[p])));
    end

    // underrun: two samples, sixteen pulses, flat extension at 80
    model_s = '{0, 80};
    start(0);
    push_raw(0);
    push_raw(80);
    wait_run("und_run");
    model_pulses("und", 7, 0);
    check("und_before", int'(underrun), 0);
    model_pulses("und", 1, 0);
    check("und_at8", int'(underrun), 1);
    model_pulses("und", 8, 0);
    check("und_hold", int'(underrun), 1);
    enable = 1'b0;
    tick();
    tick();
    check("und_sticky_idle", int'(underrun), 1);
    enable = 1'b1;
    tick();
    check("und_cleared", int'(underrun), 0);

    // overflow / full: 2 loaded, 4 buffered, 1 dropped
    model_s = '{0, 80, 11, 22, 33, 44};
    start(0);
    push_raw(0);
    push_raw(80);
    wait_run("ovf_run");
    push_raw(11);
    push_raw(22);
    push_raw(33);
    push_raw(44);
    check("ovf_count_full", int'(fifo_count), 4);
    check("ovf_in_req_low", int'(sif.in_req), 0);
    check("ovf_not_yet", int'(overflow), 0);
    push_raw(55);
    check("ovf_set", int'(overflow), 1);
    check("ovf_count_kept", int'(fifo_count), 4);
    model_pulses("ovf", 40, 0);
    check("ovf_end_underrun", int'(underrun), 1);

    // disable mid-RUN at phase 4
    model_s = '{0, 80};
    start(0);
    push_raw(0);
    push_raw(80);
    wait_run("dis_run");
    push_raw(11);
    push_raw(22);
    model_pulses("dis", 4, 0);
    check("dis_count_pre", int'(fifo_count), 2);
    enable = 1'b0;
    tick();
    check("dis_state", int'(fsm_state), int'(IDLE));
    check("dis_count", int'(fifo_count), 0);
    check("dis_in_req", int'(sif.in_req), 0);
    pulse("dis_out_zero", 0);

    // reset mid-RUN with overflow set and non-zero output
    start(0);
    push_raw(0);
    push_raw(80);
    wait_run("rmid_run");
    for (int i = 1; i <= 5; i++) push_raw(i);
    check("rmid_ovf", int'(overflow), 1);
    pulse("rmid_p0", 0);
    pulse("rmid_p1", 10);
    pulse("rmid_p2", 20);
    reset = 1'b1;
    tick();
    check("rmid_data", int'(to_ac97_data), 0);
    check("rmid_in_req", int'(sif.in_req), 0);
    check("rmid_overflow", int'(overflow), 0);
    check("rmid_underrun", int'(underrun), 0);
    check("rmid_state", int'(fsm_state), int'(IDLE));
    check("rmid_count", int'(fifo_count), 0);
    reset = 1'b0;
    enable = 1'b0;
    tick();

    // random sessions fed through in_req
    for (int s = 0; s < 8; s++) begin
      int n_samp, n_pulse, vol;
      n_samp = $urandom_range(3, 7);
      n_pulse = $urandom_range(8, 8 * n_samp);
      vol = $urandom_range(0, 7);
      model_s.delete();
      feed_q.delete();
      for (int i = 0; i < n_samp; i++) begin
        int x;
        x = $urandom_range(0, 255) - 128;
        model_s.push_back(x);
        feed_q.push_back(x);
      end
      feed_on = 1'b1;
      start(vol);
      wait_run($sformatf("rnd%0d_run", s));
      model_pulses($sformatf("rnd%0d", s), n_pulse, vol);
      check($sformatf("rnd%0d_underrun", s), int'(underrun), (n_pulse >= 8 * (n_samp - 1)) ? 1 : 0);
      check($sformatf("rnd%0d_overflow", s), int'(overflow), 0);
      feed_on = 1'b0;
      enable = 1'b0;
      tick();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
